// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: request/response bundle for the shared comparator.
//   i_req_valid[1:0]  per-requester request valid (0 = branch unit, 1 = ALU slt)
//   o_req_ready[1:0]  per-requester accept (at most one bit high)
//   i_req_a0/b0, i_req_a1/b1  operands per requester
//   i_req_signed[1:0] per-requester compare mode (1 = signed)
//   i_req_op0/op1     operation: 00 LT, 01 GE, 10 EQ, 11 NE
//   o_rsp_valid, o_rsp_id, o_rsp_result, i_rsp_ready  response handshake
// Modports: slave = comparator side, master = requesters/consumer side.
interface cmp_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       i_req_valid;
    logic [1:0]       o_req_ready;
    logic [WIDTH-1:0] i_req_a0;
    logic [WIDTH-1:0] i_req_b0;
    logic [WIDTH-1:0] i_req_a1;
    logic [WIDTH-1:0] i_req_b1;
    logic [1:0]       i_req_signed;
    logic [1:0]       i_req_op0;
    logic [1:0]       i_req_op1;
    logic             o_rsp_valid;
    logic             o_rsp_id;
    logic [WIDTH-1:0] o_rsp_result;
    logic             i_rsp_ready;

    modport slave (
        input  i_req_valid, i_req_a0, i_req_b0, i_req_a1, i_req_b1,
        input  i_req_signed, i_req_op0, i_req_op1, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
    );

    modport master (
        output i_req_valid, i_req_a0, i_req_b0, i_req_a1, i_req_b1,
        output i_req_signed, i_req_op0, i_req_op1, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
    );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters share one comparator (LT/GE/EQ/NE, signed or
// unsigned). Round-robin grant on contention, one registered result per
// accepted request, response held until the consumer takes it.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus_io   cmp_arbiter_if slave modport (request and response handshakes)
module cmp_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cmp_arbiter_if.slave  bus_io
);
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   rsp_id_q, rsp_id_d;
    logic   rsp_bit_q, rsp_bit_d;

    logic             can_accept;
    logic             grant;
    logic             accept;
    logic [1:0]       ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_signed;
    logic [1:0]       op_sel;
    logic [WIDTH:0]   diff;
    logic             lt_u, lt_s, lt, eq, cmp_bit;

    // Grant and ready
    always_comb begin
        grant = 1'b0;
        unique case (bus_io.i_req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_ptr_q;
            default: grant = 1'b0;
        endcase
        can_accept = (state_q == StIdle) || bus_io.i_rsp_ready;
        ready = 2'b00;
        // Reset gating keeps ready low while reset is held.
        if (i_rst_n && can_accept && (bus_io.i_req_valid != 2'b00)) begin
            ready = grant ? 2'b10 : 2'b01;
        end
        accept = |ready;
    end

    assign bus_io.o_req_ready = ready;

    // Shared comparator on the granted requester's operands
    always_comb begin
        op_a      = grant ? bus_io.i_req_a1 : bus_io.i_req_a0;
        op_b      = grant ? bus_io.i_req_b1 : bus_io.i_req_b0;
        op_signed = bus_io.i_req_signed[grant];
        op_sel    = grant ? bus_io.i_req_op1 : bus_io.i_req_op0;
        diff      = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        lt_u      = ~diff[WIDTH];
        // Differing signs: the negative operand is the smaller one.
        lt_s      = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_a[WIDTH-1] : diff[WIDTH-1];
        lt        = op_signed ? lt_s : lt_u;
        eq        = (op_a == op_b);
        cmp_bit   = 1'b0;
        unique case (op_sel)
            2'b00:   cmp_bit = lt;
            2'b01:   cmp_bit = ~lt;
            2'b10:   cmp_bit = eq;
            2'b11:   cmp_bit = ~eq;
            default: cmp_bit = 1'b0;
        endcase
    end

    // FSM / response next state
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_bit_d = rsp_bit_q;
        if (accept) begin
            state_d   = StHold;
            rr_ptr_d  = ~grant;
            rsp_id_d  = grant;
            rsp_bit_d = cmp_bit;
        end else if ((state_q == StHold) && bus_io.i_rsp_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_bit_q <= rsp_bit_d;
        end
    end

    assign bus_io.o_rsp_valid  = (state_q == StHold);
    assign bus_io.o_rsp_id     = rsp_id_q;
    assign bus_io.o_rsp_result = {{(WIDTH-1){1'b0}}, rsp_bit_q};
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: scoreboard bench for cmp_arbiter. The driver predicts each
// accept from a reference model and queues the expected response; a monitor
// compares responses as the DUT presents them.
module tb_cmp_arbiter;
    localparam int unsigned W = 32;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
    } rsp_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    cmp_arbiter_if #(.WIDTH(W)) bus ();

    cmp_arbiter #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus_io  (bus)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t exp_q[$];
    logic model_hold = 1'b0;
    logic model_rr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference compare straight from the operation definitions.
    function automatic logic [W-1:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn, input logic [1:0] op);
        logic lt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            2'b00:   return W'(lt);
            2'b01:   return W'(!lt);
            2'b10:   return W'(a == b);
            default: return W'(a != b);
        endcase
    endfunction

    // One clock: predict at negedge, commit at the posedge, then return at +1.
    task automatic cycle();
        logic       g;
        logic       can;
        logic [1:0] exp_rdy;
        rsp_t       item;
        @(negedge i_clk);
        can = !model_hold || bus.i_rsp_ready;
        case (bus.i_req_valid)
            2'b10:   g = 1'b1;
            2'b11:   g = model_rr;
            default: g = 1'b0;
        endcase
        exp_rdy = (can && bus.i_req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", {62'd0, bus.o_req_ready}, {62'd0, exp_rdy});
        item.id  = g;
        item.res = g ? ref_cmp(bus.i_req_a1, bus.i_req_b1, bus.i_req_signed[1], bus.i_req_op1)
                     : ref_cmp(bus.i_req_a0, bus.i_req_b0, bus.i_req_signed[0], bus.i_req_op0);
        @(posedge i_clk);
        if (exp_rdy != 2'b00) begin
            exp_q.push_back(item);
            model_hold = 1'b1;
            model_rr   = ~g;
        end else if (model_hold && bus.i_rsp_ready) begin
            model_hold = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic rr,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [1:0] op0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [1:0] op1, input logic [1:0] sgn);
        bus.i_req_valid  = v;
        bus.i_rsp_ready  = rr;
        bus.i_req_a0     = a0;
        bus.i_req_b0     = b0;
        bus.i_req_op0    = op0;
        bus.i_req_a1     = a1;
        bus.i_req_b1     = b1;
        bus.i_req_op1    = op1;
        bus.i_req_signed = sgn;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: response must match the queue head; pop on handshake.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check("rsp_valid", {63'd0, bus.o_rsp_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0 && bus.o_rsp_valid) begin
                check("rsp_id", {63'd0, bus.o_rsp_id}, {63'd0, exp_q[0].id});
                check("rsp_result", {32'd0, bus.o_rsp_result}, {32'd0, exp_q[0].res});
                if (bus.i_rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] x, y;
        set_req(2'b11, 1'b1, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00);
        #2;
        check("reset_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
        check("reset_rsp_id", {63'd0, bus.o_rsp_id}, 64'd0);
        check("reset_rsp_result", {32'd0, bus.o_rsp_result}, 64'd0);
        check("reset_req_ready", {62'd0, bus.o_req_ready}, 64'd0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;

        // Contention with consumer always ready: strict 0,1,0,1 alternation.
        repeat (6) cycle();
        set_req(2'b00, 1'b1, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00);
        repeat (2) cycle();

        // Signed vs unsigned LT on the same operands.
        set_req(2'b01, 1'b1, 32'hFFFF_FFFF, 32'h1, 2'b00, '0, '0, 2'b00, 2'b01);
        cycle();
        set_req(2'b01, 1'b1, 32'hFFFF_FFFF, 32'h1, 2'b00, '0, '0, 2'b00, 2'b00);
        cycle();
        // Overflow-prone signed pair, then EQ/NE on requester 1.
        set_req(2'b01, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00, '0, '0, 2'b00, 2'b01);
        cycle();
        set_req(2'b01, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, '0, '0, 2'b00, 2'b01);
        cycle();
        set_req(2'b10, 1'b1, '0, '0, 2'b00, 32'h1234_5678, 32'h1234_5678, 2'b10, 2'b10);
        cycle();
        set_req(2'b10, 1'b1, '0, '0, 2'b00, 32'h1234_5678, 32'h1234_5678, 2'b11, 2'b00);
        cycle();

        // Backpressure: hold a response for 5 cycles, then hand over to req1.
        set_req(2'b01, 1'b0, 32'h5, 32'h9, 2'b00, 32'h3, 32'h3, 2'b10, 2'b00);
        cycle();
        bus.i_req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            bus.i_req_a1 = $urandom;
            cycle();
        end
        bus.i_req_a1 = 32'h3;
        bus.i_rsp_ready = 1'b1;
        cycle();
        bus.i_req_valid = 2'b00;
        repeat (2) cycle();

        // Reset between edges while a response is held.
        set_req(2'b10, 1'b0, '0, '0, 2'b00, 32'h1, 32'h2, 2'b00, 2'b00);
        cycle();
        cycle();
        #2 i_rst_n = 1'b0;
        bus.i_req_valid = 2'b11;
        #1;
        check("midrst_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
        check("midrst_rsp_id", {63'd0, bus.o_rsp_id}, 64'd0);
        check("midrst_rsp_result", {32'd0, bus.o_rsp_result}, 64'd0);
        check("midrst_req_ready", {62'd0, bus.o_req_ready}, 64'd0);
        exp_q.delete();
        model_hold = 1'b0;
        model_rr   = 1'b0;
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        repeat (3) cycle();

        // Random traffic; operands wiggle whether granted or not.
        for (int i = 0; i < 400; i++) begin
            x = rnd_operand();
            y = ($urandom_range(0, 3) == 0) ? x : rnd_operand();
            set_req(2'($urandom), ($urandom_range(0, 3) != 0), x, y, 2'($urandom),
                    rnd_operand(), rnd_operand(), 2'($urandom), 2'($urandom));
            cycle();
        end

        set_req(2'b00, 1'b1, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00);
        repeat (3) cycle();
        check("drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits.
REQ-002 Port: i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_req_valid  input  2  per-requester request valid; bit 0 = requester 0 (branch unit), bit 1 = requester 1 (ALU set-less-than).
REQ-005 Port: o_req_ready  output  2  per-requester accept; a request transfers when valid and ready are both high on a rising edge.
REQ-006 Port: i_req_a0, i_req_b0, i_req_a1, i_req_b1  input  WIDTH each  operands per requester.
REQ-007 Port: i_req_signed  input  2  per-requester compare mode: 1 = signed two's complement, 0 = unsigned.
REQ-008 Port: i_req_op0, i_req_op1  input  2 each  operation: 00 LT, 01 GE, 10 EQ, 11 NE.
REQ-009 Port: o_rsp_valid  output  1  response valid.
REQ-010 Port: o_rsp_id  output  1  requester index the response belongs to.
REQ-011 Port: o_rsp_result  output  WIDTH  compare result, zero-extended: 1 if condition true, else 0.
REQ-012 Port: i_rsp_ready  input  1  consumer accepts the response when high with o_rsp_valid high.

Function
REQ-013 The block shall share one internal comparator between the two requesters and produce one result per accepted request.
REQ-014 The FSM shall have two states: IDLE (no result held) and HOLD (result held, o_rsp_valid=1).
REQ-015 "Can accept" shall be true in IDLE, or in HOLD with i_rsp_ready=1 in the same cycle.
REQ-016 Grant rule: if exactly one i_req_valid bit is set, that requester is granted.
REQ-017 Grant rule: if both bits are set, the requester selected by the round-robin pointer rr_ptr is granted.
REQ-018 o_req_ready[r] shall be 1 only for the granted requester and only when "can accept" is true; at most one bit is high per cycle.
REQ-019 On an accepted transfer, rr_ptr shall move to the non-granted requester; otherwise rr_ptr shall hold.
REQ-020 Latency: a request accepted on edge N shall present o_rsp_valid=1, o_rsp_id and o_rsp_result from edge N onward, i.e. valid in cycle N+1.
REQ-021 The response registers and the FSM shall go to or stay in HOLD on acceptance.
REQ-022 Signed LT: if the operand sign bits differ, the result is a[WIDTH-1].
REQ-023 Signed LT: if the sign bits are equal, the result is the MSB of (a + ~b + 1) truncated to WIDTH.
REQ-024 Unsigned LT shall equal NOT carry-out of (a + ~b + 1).
REQ-025 GE = NOT LT, EQ = (a == b), NE = NOT EQ.
REQ-026 Signed/unsigned selection shall not affect EQ or NE.
REQ-027 In HOLD with i_rsp_ready=0, o_rsp_valid, o_rsp_id and o_rsp_result shall remain stable and o_req_ready shall be 00.
REQ-028 In HOLD with i_rsp_ready=1 and no request accepted, the FSM shall return to IDLE and o_rsp_valid shall drop on the next edge.
REQ-029 In HOLD with i_rsp_ready=1 and a request accepted in the same cycle, the FSM shall stay in HOLD with the new response (back-to-back, one result per cycle).
REQ-030 Requester inputs sampled only on the accepting edge; changes while not granted shall have no effect.
REQ-031 o_req_ready may depend combinationally on i_req_valid and i_rsp_ready.
REQ-032 No other output shall have a combinational input-to-output path.

Reset
REQ-033 On i_rst_n low, immediately and independent of i_clk: FSM=IDLE, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, rr_ptr=0 (requester 0 preferred).
REQ-034 While reset is asserted, o_req_ready shall be 00.
REQ-035 Reset asserted mid-HOLD shall discard the held response; no response for that request shall ever appear.
REQ-036 The first accept after reset release shall occur on the first rising edge with i_rst_n high.

Verification
REQ-037 Signed LT: req0 a=0xFFFFFFFF, b=0x00000001, signed=1, op=LT -> next cycle o_rsp_valid=1, id=0, result=0x00000001; the same operands with signed=0 -> result=0x00000000.
REQ-038 Overflow case: a=0x80000000, b=0x7FFFFFFF, signed=1 -> LT gives 0x1 and GE gives 0x0; EQ with a=b=0x12345678 -> 0x1; NE with the same operands -> 0x0.
REQ-039 Contention: after reset, both valid with i_rsp_ready=1 held -> cycle 1 ready=01, cycle 2 ready=10; responses id 0 then id 1 on consecutive cycles; with both still valid, alternation continues 0,1,0,1.
REQ-040 Backpressure: response held with i_rsp_ready=0 for 5 cycles -> result and id stable, o_req_ready=00; raise i_rsp_ready with req1 valid -> req1 accepted that cycle and its response appears the next cycle.
REQ-041 Reset mid-operation: drop i_rst_n between clock edges while o_rsp_valid=1 -> o_rsp_valid, id and result go to 0 before the next edge; after release, both valid -> requester 0 is granted first.
